// File: rtl/mips_pkg.sv
// mips_pkg: shared definitions for the register file slice.
//   DATA_W_DEF / ADDR_W_DEF : default data and address widths
//   clr_state_e             : bulk-clear FSM state encoding
`timescale 1ns/1ps
package mips_pkg;
   localparam int DATA_W_DEF = 8;
   localparam int ADDR_W_DEF = 4;

   typedef enum logic {
      CLR_IDLE  = 1'b0,
      CLR_CLEAR = 1'b1
   } clr_state_e;
endpackage

// File: rtl/regfile_clr_fsm.sv
// regfile_clr_fsm: sequences a bulk clear over every register address.
//   clk, rst (async, active-low)
//   clr_req  : pulse that starts a clear (ignored while busy)
//   clr_busy : high for 2**ADDR_W cycles while the clear runs
//   clr_done : high on the cycle the last address is cleared
//   clr_addr : address being cleared this cycle
`timescale 1ns/1ps
module regfile_clr_fsm
   import mips_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clr_req,
   output logic              clr_busy,
   output logic              clr_done,
   output logic [ADDR_W-1:0] clr_addr
);

   localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

   clr_state_e        state_q, state_d;
   logic [ADDR_W-1:0] cnt_q, cnt_d;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= CLR_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      clr_busy = 1'b0;
      clr_done = 1'b0;
      case (state_q)
         CLR_IDLE: begin
            if (clr_req) begin
               state_d = CLR_CLEAR;
               cnt_d   = '0;
            end
         end
         CLR_CLEAR: begin
            clr_busy = 1'b1;
            // Leaving CLEAR is the only way the counter returns to 0.
            if (cnt_q == LAST_ADDR) begin
               clr_done = 1'b1;
               state_d  = CLR_IDLE;
               cnt_d    = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = CLR_IDLE;
      endcase
   end

   assign clr_addr = cnt_q;

endmodule

// File: rtl/register_file_p.sv
// register_file_p: 2-read / 1-write register file with bulk clear.
//   clk, rst (async, active-low)
//   reg_write_en/dest/data        : write port
//   reg_read_addr_1/2, data_1/2   : combinational read ports
//   clr_req, clr_busy, clr_done   : bulk clear control/status
//   wr_stall                      : write requested but dropped (clear running)
`timescale 1ns/1ps
module register_file_p
   import mips_pkg::*;
#(
   parameter int DATA_W   = DATA_W_DEF,
   parameter int ADDR_W   = ADDR_W_DEF,
   parameter bit ZERO_REG = 1'b1,
   parameter bit BYPASS   = 1'b1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              reg_write_en,
   input  logic [ADDR_W-1:0] reg_write_dest,
   input  logic [DATA_W-1:0] reg_write_data,
   input  logic [ADDR_W-1:0] reg_read_addr_1,
   input  logic [ADDR_W-1:0] reg_read_addr_2,
   output logic [DATA_W-1:0] reg_read_data_1,
   output logic [DATA_W-1:0] reg_read_data_2,
   input  logic              clr_req,
   output logic              clr_busy,
   output logic              clr_done,
   output logic              wr_stall
);

   localparam int DEPTH = 2**ADDR_W;

   logic [DEPTH-1:0][DATA_W-1:0] mem_q, mem_d;
   logic [ADDR_W-1:0]            clr_addr;
   logic                         wr_ok;
   logic [1:0][ADDR_W-1:0]       rd_addr;
   logic [1:0][DATA_W-1:0]       rd_data;

   regfile_clr_fsm #(.ADDR_W(ADDR_W)) u_clr_fsm (
      .clk      (clk),
      .rst      (rst),
      .clr_req  (clr_req),
      .clr_busy (clr_busy),
      .clr_done (clr_done),
      .clr_addr (clr_addr)
   );

   // A write lands only outside a clear and never into the hardwired zero.
   assign wr_ok    = reg_write_en && !clr_busy &&
                     !(ZERO_REG && (reg_write_dest == '0));
   assign wr_stall = reg_write_en && clr_busy;

   always_comb begin
      mem_d = mem_q;
      if (clr_busy)
         mem_d[clr_addr] = '0;
      else if (wr_ok)
         mem_d[reg_write_dest] = reg_write_data;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) mem_q <= '0;
      else      mem_q <= mem_d;
   end

   // Bypass only forwards accepted writes; the zero register overrides all.
   assign rd_addr = {reg_read_addr_2, reg_read_addr_1};

   always_comb begin
      rd_data = '0;
      for (int p = 0; p < 2; p++) begin
         rd_data[p] = mem_q[rd_addr[p]];
         if (BYPASS && wr_ok && (rd_addr[p] == reg_write_dest))
            rd_data[p] = reg_write_data;
         if (ZERO_REG && (rd_addr[p] == '0))
            rd_data[p] = '0;
      end
   end

   assign reg_read_data_1 = rd_data[0];
   assign reg_read_data_2 = rd_data[1];

endmodule

// File: tb/tb_register_file_p.sv
`timescale 1ns/1ps
module tb_register_file_p;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #10 clk = ~clk;

   // group A: 8-bit x 16 (u_a0 with bypass, u_a1 without); group B: 32-bit x 32
   logic       a_we, a_clr;
   logic [3:0] a_dest, a_ra1, a_ra2;
   logic [7:0] a_wdata;
   logic [7:0] a0_rd1, a0_rd2, a1_rd1, a1_rd2;
   logic       a0_busy, a0_done, a0_stall, a1_busy, a1_done, a1_stall;

   logic        b_we, b_clr;
   logic [4:0]  b_dest, b_ra1, b_ra2;
   logic [31:0] b_wdata, b_rd1, b_rd2;
   logic        b_busy, b_done, b_stall;

   register_file_p #(.DATA_W(8), .ADDR_W(4), .ZERO_REG(1'b1), .BYPASS(1'b1)) u_a0 (
      .clk(clk), .rst(rst), .reg_write_en(a_we), .reg_write_dest(a_dest),
      .reg_write_data(a_wdata), .reg_read_addr_1(a_ra1), .reg_read_addr_2(a_ra2),
      .reg_read_data_1(a0_rd1), .reg_read_data_2(a0_rd2), .clr_req(a_clr),
      .clr_busy(a0_busy), .clr_done(a0_done), .wr_stall(a0_stall));

   register_file_p #(.DATA_W(8), .ADDR_W(4), .ZERO_REG(1'b1), .BYPASS(1'b0)) u_a1 (
      .clk(clk), .rst(rst), .reg_write_en(a_we), .reg_write_dest(a_dest),
      .reg_write_data(a_wdata), .reg_read_addr_1(a_ra1), .reg_read_addr_2(a_ra2),
      .reg_read_data_1(a1_rd1), .reg_read_data_2(a1_rd2), .clr_req(a_clr),
      .clr_busy(a1_busy), .clr_done(a1_done), .wr_stall(a1_stall));

   register_file_p #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1'b1), .BYPASS(1'b1)) u_b (
      .clk(clk), .rst(rst), .reg_write_en(b_we), .reg_write_dest(b_dest),
      .reg_write_data(b_wdata), .reg_read_addr_1(b_ra1), .reg_read_addr_2(b_ra2),
      .reg_read_data_1(b_rd1), .reg_read_data_2(b_rd2), .clr_req(b_clr),
      .clr_busy(b_busy), .clr_done(b_done), .wr_stall(b_stall));

   // ---------------- reference model ----------------
   logic [7:0]  ma [16];
   logic [31:0] mb [32];
   int a_cidx = -1;   // index being cleared this cycle, -1 when no clear runs
   int b_cidx = -1;

   typedef struct {
      logic [7:0]  a0r1, a0r2, a1r1, a1r2;
      logic        ab, ad, as;
      logic [31:0] br1, br2;
      logic        bb, bd, bs;
   } exp_t;

   exp_t sb[$];
   int   n_chk  = 0;
   int   n_fail = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [7:0] mod_a(input logic [3:0] ra, input bit byp);
      if (ra == 0) return 8'h00;
      if (byp && a_we && a_cidx < 0 && a_dest != 0 && ra == a_dest) return a_wdata;
      return ma[ra];
   endfunction

   function automatic logic [31:0] mod_b(input logic [4:0] ra);
      if (ra == 0) return 32'h0;
      if (b_we && b_cidx < 0 && b_dest != 0 && ra == b_dest) return b_wdata;
      return mb[ra];
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 16; i++) ma[i] = 8'h00;
      for (int i = 0; i < 32; i++) mb[i] = 32'h0;
      a_cidx = -1;
      b_cidx = -1;
   endtask

   // One clock cycle: predict outputs for current inputs, then advance the model.
   task automatic step();
      exp_t e;
      e.a0r1 = mod_a(a_ra1, 1'b1);  e.a0r2 = mod_a(a_ra2, 1'b1);
      e.a1r1 = mod_a(a_ra1, 1'b0);  e.a1r2 = mod_a(a_ra2, 1'b0);
      e.ab = (a_cidx >= 0);  e.ad = (a_cidx == 15);  e.as = a_we && (a_cidx >= 0);
      e.br1 = mod_b(b_ra1);  e.br2 = mod_b(b_ra2);
      e.bb = (b_cidx >= 0);  e.bd = (b_cidx == 31);  e.bs = b_we && (b_cidx >= 0);
      sb.push_back(e);
      @(posedge clk);
      if (a_cidx >= 0) begin
         ma[a_cidx] = 8'h00;
         a_cidx = (a_cidx == 15) ? -1 : a_cidx + 1;
      end else begin
         if (a_we && a_dest != 0) ma[a_dest] = a_wdata;
         if (a_clr) a_cidx = 0;
      end
      if (b_cidx >= 0) begin
         mb[b_cidx] = 32'h0;
         b_cidx = (b_cidx == 31) ? -1 : b_cidx + 1;
      end else begin
         if (b_we && b_dest != 0) mb[b_dest] = b_wdata;
         if (b_clr) b_cidx = 0;
      end
      #1;
   endtask

   // Same intent to both groups; group A sees the low bits of dest/data.
   task automatic drive(input bit we, input int dest, input logic [31:0] data,
                        input int ra1, input int ra2, input bit clr);
      a_we = we;  a_dest = 4'(dest);  a_wdata = data[7:0];
      a_ra1 = 4'(ra1);  a_ra2 = 4'(ra2);  a_clr = clr;
      b_we = we;  b_dest = 5'(dest);  b_wdata = data;
      b_ra1 = 5'(ra1);  b_ra2 = 5'(ra2);  b_clr = clr;
      step();
   endtask

   task automatic idle_inputs();
      a_we = 0; a_clr = 0; a_dest = 0; a_wdata = 0; a_ra1 = 0; a_ra2 = 0;
      b_we = 0; b_clr = 0; b_dest = 0; b_wdata = 0; b_ra1 = 0; b_ra2 = 0;
   endtask

   task automatic chk_status_low(input string tag);
      chk({tag, "_a0_busy"}, a0_busy, 0);  chk({tag, "_a0_done"}, a0_done, 0);
      chk({tag, "_a0_stall"}, a0_stall, 0); chk({tag, "_a1_busy"}, a1_busy, 0);
      chk({tag, "_b_busy"}, b_busy, 0);    chk({tag, "_b_done"}, b_done, 0);
      chk({tag, "_b_stall"}, b_stall, 0);
   endtask

   // Reset pulse between edges; all registers must read 0 with no edge needed.
   task automatic reset_test(input string tag);
      @(negedge clk); #1;
      idle_inputs();
      a_we = 1; b_we = 1;            // requested writes must not stall in reset
      rst = 0;
      #1;
      chk_status_low(tag);
      a_we = 0; b_we = 0;
      #1;
      rst = 1;
      model_reset();
      @(posedge clk); #1;
      for (int i = 0; i < 16; i++) begin
         a_ra1 = 4'(i); a_ra2 = 4'(15 - i);
         b_ra1 = 5'(i); b_ra2 = 5'(31 - i);
         #1;
         chk({tag, "_a0_rd1"}, a0_rd1, 0); chk({tag, "_a0_rd2"}, a0_rd2, 0);
         chk({tag, "_a1_rd1"}, a1_rd1, 0); chk({tag, "_b_rd1"}, b_rd1, 0);
         chk({tag, "_b_rd2"}, b_rd2, 0);
      end
      @(posedge clk); #1;
   endtask

   // ---------------- monitor ----------------
   always @(negedge clk) begin
      if (sb.size() > 0) begin
         exp_t e;
         e = sb.pop_front();
         chk("a0_rd1", a0_rd1, e.a0r1);  chk("a0_rd2", a0_rd2, e.a0r2);
         chk("a1_rd1", a1_rd1, e.a1r1);  chk("a1_rd2", a1_rd2, e.a1r2);
         chk("a0_busy", a0_busy, e.ab);  chk("a0_done", a0_done, e.ad);
         chk("a0_stall", a0_stall, e.as);
         chk("a1_busy", a1_busy, e.ab);  chk("a1_done", a1_done, e.ad);
         chk("a1_stall", a1_stall, e.as);
         chk("b_rd1", b_rd1, e.br1);     chk("b_rd2", b_rd2, e.br2);
         chk("b_busy", b_busy, e.bb);    chk("b_done", b_done, e.bd);
         chk("b_stall", b_stall, e.bs);
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      int done_a, done_b;
      idle_inputs();
      model_reset();
      a_ra1 = 4'd3; b_ra1 = 5'd7;
      repeat (2) @(posedge clk);
      #1;
      chk_status_low("por");
      chk("por_a0_rd1", a0_rd1, 0);
      chk("por_b_rd1", b_rd1, 0);
      rst = 1;

      // write accepted on the first edge after reset release; fill with A5
      for (int i = 0; i < 32; i++) drive(1, i, 32'hA5A5_A5A5, i, 31 - i, 0);
      drive(0, 0, 0, 7, 20, 0);
      reset_test("rst");

      // write/read and zero register
      drive(1, 5, 32'hDEAD_BE3C, 0, 0, 0);
      drive(1, 0, 32'hFFFF_FFFF, 5, 0, 0);
      drive(0, 0, 0, 5, 0, 0);

      // bypass: old value 42, same-cycle write of 77 on read port 2
      drive(1, 9, 32'h0000_0042, 0, 0, 0);
      drive(1, 9, 32'h1234_5677, 3, 9, 0);
      drive(0, 0, 0, 9, 9, 0);

      // bulk clear, fill descending so each register ends at its own index
      for (int i = 31; i >= 0; i--) drive(1, i, i, i, 0, 0);
      for (int i = 0; i < 32; i++) drive(0, 0, 0, i, 31 - i, 0);
      drive(0, 0, 0, 1, 2, 1);
      done_a = 0; done_b = 0;
      for (int c = 0; c < 32; c++) begin
         if (c == 3)      drive(1, 15, 32'h11, 15, 31, 0);
         else if (c == 5) drive(0, 0, 0, c, 31 - c, 1);   // ignored while busy
         else             drive(0, 0, 0, c, 31 - c, 0);
      end
      for (int i = 0; i < 32; i++) drive(0, 0, 0, i, 31 - i, 0);

      // randomized traffic
      for (int n = 0; n < 600; n++)
         drive(bit'($urandom_range(0, 1)), int'($urandom_range(0, 31)), $urandom,
               int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
               ($urandom_range(0, 24) == 0));
      // let any clear still running finish under random reads
      for (int n = 0; n < 40; n++)
         drive(bit'($urandom_range(0, 1)), int'($urandom_range(0, 31)), $urandom,
               int'($urandom_range(0, 31)), int'($urandom_range(0, 31)), 0);

      // abort a clear with reset midway
      for (int i = 1; i < 32; i++) drive(1, i, 32'h5A5A_0000 + i, 0, 0, 0);
      drive(0, 0, 0, 0, 0, 1);
      for (int c = 0; c < 6; c++) drive(0, 0, 0, 20, 10, 0);
      reset_test("abort");
      for (int i = 0; i < 40; i++) drive(0, 0, 0, i % 32, 31 - (i % 32), 0);

      @(negedge clk); #1;
      chk("sb_drained", 32'(sb.size()), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
